// File: rtl/multi_block_selector.sv
// multi_block_selector: pipelined arg-min over per-block ray hits, with tags in lockstep and a global stall
module multi_block_selector #(
  parameter int NUM_BLOCKS = 12,
  parameter int T_WIDTH = 32,
  parameter int ATTR_WIDTH = 38,
  localparam int LEVELS = $clog2(NUM_BLOCKS),
  localparam int IDX_W = (LEVELS < 1) ? 1 : LEVELS
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             valid_in,
  output logic                             ready_out,
  input  logic [17:0]                      curr_time_in,
  input  logic [10:0]                      x_in,
  input  logic [9:0]                       y_in,
  input  logic [NUM_BLOCKS*T_WIDTH-1:0]    t_in,
  input  logic [NUM_BLOCKS-1:0]            hit_in,
  input  logic [NUM_BLOCKS*ATTR_WIDTH-1:0] attr_in,
  input  logic [T_WIDTH-1:0]               t_max_in,
  output logic                             valid_out,
  input  logic                             ready_in,
  output logic [17:0]                      curr_time_out,
  output logic [10:0]                      x_out,
  output logic [9:0]                       y_out,
  output logic [IDX_W-1:0]                 block_index_out,
  output logic [T_WIDTH-1:0]               t_out,
  output logic [ATTR_WIDTH-1:0]            attr_out,
  output logic                             block_visible_out
);
  logic [LEVELS:0]        r_v;
  logic                   r_q    [0:LEVELS][0:NUM_BLOCKS-1];
  logic [T_WIDTH-1:0]     r_t    [0:LEVELS][0:NUM_BLOCKS-1];
  logic [IDX_W-1:0]       r_i    [0:LEVELS][0:NUM_BLOCKS-1];
  logic [ATTR_WIDTH-1:0]  r_a    [0:LEVELS][0:NUM_BLOCKS-1];
  logic                   w_q    [0:LEVELS][0:NUM_BLOCKS-1];
  logic [T_WIDTH-1:0]     w_t    [0:LEVELS][0:NUM_BLOCKS-1];
  logic [IDX_W-1:0]       w_i    [0:LEVELS][0:NUM_BLOCKS-1];
  logic [ATTR_WIDTH-1:0]  w_a    [0:LEVELS][0:NUM_BLOCKS-1];
  logic [17:0]            r_time [0:LEVELS];
  logic [10:0]            r_x    [0:LEVELS];
  logic [9:0]             r_y    [0:LEVELS];
  function automatic int cnt(input int l);
    return (NUM_BLOCKS + (1 << l) - 1) >> l;
  endfunction
  assign valid_out = r_v[LEVELS];
  assign ready_out = !(valid_out && !ready_in);
  assign block_visible_out = valid_out && r_q[LEVELS][0];
  assign block_index_out = r_i[LEVELS][0];
  assign t_out = r_t[LEVELS][0];
  assign attr_out = r_a[LEVELS][0];
  assign curr_time_out = r_time[LEVELS];
  assign x_out = r_x[LEVELS];
  assign y_out = r_y[LEVELS];
  // Level 0 is the qualified candidate set; level l reduces pairs of level l-1, odd tail passes through
  always_comb begin
    int a, b, s;
    a = 0;
    b = 0;
    s = 0;
    for (int l = 0; l <= LEVELS; l++)
      for (int j = 0; j < NUM_BLOCKS; j++) begin
        w_q[l][j] = 1'b0;
        w_t[l][j] = '0;
        w_i[l][j] = '0;
        w_a[l][j] = '0;
      end
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      w_q[0][i] = hit_in[i] && (t_in[i*T_WIDTH +: T_WIDTH] <= t_max_in);
      w_t[0][i] = w_q[0][i] ? t_in[i*T_WIDTH +: T_WIDTH] : '1;
      w_i[0][i] = IDX_W'(i);
      w_a[0][i] = w_q[0][i] ? attr_in[i*ATTR_WIDTH +: ATTR_WIDTH] : '0;
    end
    for (int l = 1; l <= LEVELS; l++)
      for (int j = 0; j < NUM_BLOCKS; j++)
        if (j < cnt(l)) begin
          a = 2 * j;
          b = (2 * j + 1 < cnt(l - 1)) ? 2 * j + 1 : 2 * j;
          s = (r_q[l-1][b] && (!r_q[l-1][a] || r_t[l-1][b] < r_t[l-1][a])) ? b : a;
          w_q[l][j] = r_q[l-1][s];
          w_t[l][j] = r_t[l-1][s];
          w_i[l][j] = r_i[l-1][s];
          w_a[l][j] = r_a[l-1][s];
        end
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) r_v <= '0;
    else if (ready_out) begin
      r_v[0] <= valid_in;
      for (int l = 1; l <= LEVELS; l++) r_v[l] <= r_v[l-1];
    end
  // Data is only meaningful under its valid bit, so it carries no reset
  always_ff @(posedge clk_in)
    if (ready_out)
      for (int l = 0; l <= LEVELS; l++)
        if (l > 0 || valid_in) begin
          for (int j = 0; j < NUM_BLOCKS; j++) begin
            r_q[l][j] <= w_q[l][j];
            r_t[l][j] <= w_t[l][j];
            r_i[l][j] <= w_i[l][j];
            r_a[l][j] <= w_a[l][j];
          end
          r_time[l] <= (l == 0) ? curr_time_in : r_time[(l == 0) ? 0 : l-1];
          r_x[l] <= (l == 0) ? x_in : r_x[(l == 0) ? 0 : l-1];
          r_y[l] <= (l == 0) ? y_in : r_y[(l == 0) ? 0 : l-1];
        end
endmodule

// File: tb/tb_multi_block_selector.sv
// tb_multi_block_selector: directed checks of the selector at 12, 5 and 1 candidate blocks
module tb_multi_block_selector;
  localparam int TW = 32;
  localparam int AW = 38;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic a_vi = 0, a_ro, a_vo, a_ri = 1, a_vis;
  logic [17:0] a_ti = '0, a_to;
  logic [10:0] a_xi = '0, a_xo;
  logic [9:0] a_yi = '0, a_yo;
  logic [12*TW-1:0] a_t = '0;
  logic [11:0] a_hit = '0;
  logic [12*AW-1:0] a_attr = '0;
  logic [TW-1:0] a_tmax = '0, a_tout;
  logic [3:0] a_idx;
  logic [AW-1:0] a_aout;
  logic b_vi = 0, b_ro, b_vo, b_vis;
  logic [17:0] b_to;
  logic [10:0] b_xo;
  logic [9:0] b_yo;
  logic [5*TW-1:0] b_t = '0;
  logic [4:0] b_hit = '0;
  logic [5*AW-1:0] b_attr = '0;
  logic [TW-1:0] b_tmax = '0, b_tout;
  logic [2:0] b_idx;
  logic [AW-1:0] b_aout;
  logic c_vi = 0, c_ro, c_vo, c_vis;
  logic [17:0] c_to;
  logic [10:0] c_xo;
  logic [9:0] c_yo;
  logic [TW-1:0] c_t = '0, c_tmax = '0, c_tout;
  logic [0:0] c_hit = '0, c_idx;
  logic [AW-1:0] c_attr = '0, c_aout;

  multi_block_selector #(.NUM_BLOCKS(12), .T_WIDTH(TW), .ATTR_WIDTH(AW)) dut (
    .clk_in(clk), .rst_in(rst_n), .valid_in(a_vi), .ready_out(a_ro),
    .curr_time_in(a_ti), .x_in(a_xi), .y_in(a_yi), .t_in(a_t), .hit_in(a_hit),
    .attr_in(a_attr), .t_max_in(a_tmax), .valid_out(a_vo), .ready_in(a_ri),
    .curr_time_out(a_to), .x_out(a_xo), .y_out(a_yo), .block_index_out(a_idx),
    .t_out(a_tout), .attr_out(a_aout), .block_visible_out(a_vis));
  multi_block_selector #(.NUM_BLOCKS(5), .T_WIDTH(TW), .ATTR_WIDTH(AW)) dut5 (
    .clk_in(clk), .rst_in(rst_n), .valid_in(b_vi), .ready_out(b_ro),
    .curr_time_in(18'd5), .x_in(11'd5), .y_in(10'd5), .t_in(b_t), .hit_in(b_hit),
    .attr_in(b_attr), .t_max_in(b_tmax), .valid_out(b_vo), .ready_in(1'b1),
    .curr_time_out(b_to), .x_out(b_xo), .y_out(b_yo), .block_index_out(b_idx),
    .t_out(b_tout), .attr_out(b_aout), .block_visible_out(b_vis));
  multi_block_selector #(.NUM_BLOCKS(1), .T_WIDTH(TW), .ATTR_WIDTH(AW)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .valid_in(c_vi), .ready_out(c_ro),
    .curr_time_in(18'd1), .x_in(11'd1), .y_in(10'd1), .t_in(c_t), .hit_in(c_hit),
    .attr_in(c_attr), .t_max_in(c_tmax), .valid_out(c_vo), .ready_in(1'b1),
    .curr_time_out(c_to), .x_out(c_xo), .y_out(c_yo), .block_index_out(c_idx),
    .t_out(c_tout), .attr_out(c_aout), .block_visible_out(c_vis));

  task automatic wait_lat(input int w, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      a_vi = 0;
      b_vi = 0;
      c_vi = 0;
      lat++;
    end while (!(w == 0 ? a_vo : (w == 1 ? b_vo : c_vo)) && lat < 20);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (a_vo !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_vo); end
    checks++; if (a_vis !== 1'b0) begin failures++; $display("FAIL reset_visible got=%b exp=0", a_vis); end
    checks++; if (a_ro !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_ro); end
    checks++; if (b_vo !== 1'b0 || c_vo !== 1'b0) begin failures++; $display("FAIL reset_valid_small got=%b%b exp=00", b_vo, c_vo); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_nearest;
    int lat;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      a_t[i*TW +: TW] = TW'(100 - i);
      a_attr[i*AW +: AW] = AW'(i * 1000 + 7);
    end
    a_hit = '1; a_tmax = '1; a_ti = 18'h1234; a_xi = 11'd5; a_yi = 10'd9; a_ri = 1; a_vi = 1;
    wait_lat(0, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL nearest_latency got=%0d exp=5", lat); end
    checks++; if (a_vis !== 1'b1) begin failures++; $display("FAIL nearest_visible got=%b exp=1", a_vis); end
    checks++; if (a_idx !== 4'd11) begin failures++; $display("FAIL nearest_index got=%0d exp=11", a_idx); end
    checks++; if (a_tout !== 32'd89) begin failures++; $display("FAIL nearest_t got=%0d exp=89", a_tout); end
    checks++; if (a_aout !== 38'd11007) begin failures++; $display("FAIL nearest_attr got=%0d exp=11007", a_aout); end
    checks++; if (a_to !== 18'h1234 || a_xo !== 11'd5 || a_yo !== 10'd9) begin failures++; $display("FAIL nearest_tags got=%h/%0d/%0d exp=1234/5/9", a_to, a_xo, a_yo); end
  endtask

  task automatic test_tie_and_clip;
    int lat;
    @(negedge clk);
    for (int i = 0; i < 12; i++) a_t[i*TW +: TW] = 32'd50;
    a_t[0 +: TW] = 32'd1;
    a_hit = 12'h088; a_tmax = 32'd50; a_ti = 18'd1; a_vi = 1;
    wait_lat(0, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL tie_latency got=%0d exp=5", lat); end
    checks++; if (a_vis !== 1'b1 || a_idx !== 4'd3) begin failures++; $display("FAIL tie_index got=%b/%0d exp=1/3", a_vis, a_idx); end
    checks++; if (a_tout !== 32'd50 || a_aout !== 38'd3007) begin failures++; $display("FAIL tie_t_attr got=%0d/%0d exp=50/3007", a_tout, a_aout); end
    @(negedge clk);
    a_tmax = 32'd49; a_ti = 18'd2; a_vi = 1;
    wait_lat(0, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL clip_latency got=%0d exp=5", lat); end
    checks++; if (a_vis !== 1'b0 || a_idx !== 4'd0) begin failures++; $display("FAIL clip_miss got=%b/%0d exp=0/0", a_vis, a_idx); end
    checks++; if (a_tout !== 32'hFFFF_FFFF || a_aout !== 38'd0) begin failures++; $display("FAIL clip_t_attr got=%h/%0d exp=ffffffff/0", a_tout, a_aout); end
    checks++; if (a_to !== 18'd2) begin failures++; $display("FAIL clip_tag got=%0d exp=2", a_to); end
  endtask

  task automatic test_back_to_back;
    int sent, got, cyc;
    logic prev_stall;
    logic [17:0] prev_time;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; prev_time = '0;
    a_tmax = '1;
    @(negedge clk);
    while (got < 20 && cyc < 500) begin
      a_ri = 1'($urandom_range(0, 1));
      a_vi = (sent < 20);
      a_t = '0;
      a_hit = 12'(1) << (sent % 12);
      a_t[(sent % 12)*TW +: TW] = TW'(sent + 1);
      a_ti = 18'(sent + 100); a_xi = 11'(sent); a_yi = 10'(3 * sent);
      #1;
      if (prev_stall) begin
        checks++;
        if (a_vo !== 1'b1 || a_to !== prev_time) begin failures++; $display("FAIL stall_hold got=%b/%0d exp=1/%0d", a_vo, a_to, prev_time); end
      end
      if (a_vo && a_ri) begin
        checks++;
        if (a_idx !== 4'(got % 12) || a_tout !== TW'(got + 1) || a_to !== 18'(got + 100) || a_xo !== 11'(got) || a_yo !== 10'(3 * got))
          begin failures++; $display("FAIL stream_beat%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", got, a_idx, a_tout, a_to, got % 12, got + 1, got + 100); end
        got++;
      end
      if (a_vi && a_ro) sent++;
      prev_stall = a_vo && !a_ri;
      prev_time = a_to;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    a_vi = 0; a_ri = 1;
    checks++; if (got != 20) begin failures++; $display("FAIL stream_count got=%0d exp=20", got); end
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_vo) got++;
    end
    checks++; if (got != 0) begin failures++; $display("FAIL stream_extra got=%0d exp=0", got); end
  endtask

  task automatic test_reset_flight;
    int extra;
    @(negedge clk);
    a_ri = 1; a_hit = '1; a_tmax = '1;
    for (int k = 0; k < 5; k++) begin
      a_ti = 18'(200 + k); a_vi = 1;
      @(posedge clk);
      @(negedge clk);
    end
    a_vi = 0;
    checks++; if (a_vo !== 1'b1 || a_to !== 18'd200) begin failures++; $display("FAIL flight_pre got=%b/%0d exp=1/200", a_vo, a_to); end
    #2 rst_n = 0;
    #1;
    checks++; if (a_vo !== 1'b0 || a_vis !== 1'b0) begin failures++; $display("FAIL flight_drop got=%b/%b exp=0/0", a_vo, a_vis); end
    checks++; if (a_ro !== 1'b1) begin failures++; $display("FAIL flight_ready got=%b exp=1", a_ro); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_vo) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL flight_stale got=%0d exp=0", extra); end
  endtask

  task automatic test_five;
    int lat;
    logic [4:0] hv [4] = '{5'b10110, 5'b10000, 5'b11111, 5'b11111};
    int tv [4][5] = '{'{1, 30, 20, 5, 20}, '{1, 1, 1, 1, 7}, '{9, 8, 7, 6, 3}, '{9, 8, 7, 6, 3}};
    logic [31:0] tm [4] = '{32'd100, 32'd100, 32'd100, 32'd2};
    logic [2:0] ei [4] = '{3'd2, 3'd4, 3'd4, 3'd0};
    logic [31:0] et [4] = '{32'd20, 32'd7, 32'd3, 32'hFFFF_FFFF};
    logic [37:0] ea [4] = '{38'd102, 38'd104, 38'd104, 38'd0};
    logic ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) b_attr[i*AW +: AW] = AW'(100 + i);
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) b_t[i*TW +: TW] = TW'(tv[v][i]);
      b_hit = hv[v]; b_tmax = tm[v]; b_vi = 1;
      wait_lat(1, lat);
      checks++; if (lat != 4) begin failures++; $display("FAIL n5_latency%0d got=%0d exp=4", v, lat); end
      checks++;
      if (b_vis !== ev[v] || b_idx !== ei[v] || b_tout !== et[v] || b_aout !== ea[v])
        begin failures++; $display("FAIL n5_vec%0d got=%b/%0d/%h/%0d exp=%b/%0d/%h/%0d", v, b_vis, b_idx, b_tout, b_aout, ev[v], ei[v], et[v], ea[v]); end
    end
  endtask

  task automatic test_one;
    int lat;
    @(negedge clk);
    c_hit = 1'b1; c_t = 32'd5; c_tmax = 32'd5; c_attr = 38'h2A; c_vi = 1;
    wait_lat(2, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL n1_latency got=%0d exp=1", lat); end
    checks++; if (c_vis !== 1'b1 || c_idx !== 1'b0 || c_tout !== 32'd5 || c_aout !== 38'h2A) begin failures++; $display("FAIL n1_hit got=%b/%0d/%0d/%h exp=1/0/5/2a", c_vis, c_idx, c_tout, c_aout); end
    @(negedge clk);
    c_tmax = 32'd4; c_vi = 1;
    wait_lat(2, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL n1_miss_latency got=%0d exp=1", lat); end
    checks++; if (c_vis !== 1'b0 || c_tout !== 32'hFFFF_FFFF || c_aout !== 38'd0) begin failures++; $display("FAIL n1_miss got=%b/%h/%h exp=0/ffffffff/0", c_vis, c_tout, c_aout); end
  endtask

  initial begin
    test_reset;
    test_nearest;
    test_tie_and_clip;
    test_back_to_back;
    test_reset_flight;
    test_five;
    test_one;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_block_selector.md
MULTI_BLOCK_SELECTOR -- requirements
Module: multi_block_selector

Interface
REQ-001 Parameter NUM_BLOCKS, default 12: number of candidate blocks per pixel, legal range 1..64.
REQ-002 Parameter T_WIDTH, default 32: width of unsigned intersection distance t.
REQ-003 Parameter ATTR_WIDTH, default 38: width of packed per-block attribute word (x12, y12, z14 plus any added fields).
REQ-004 Derived constants: IDX_W = max(1, clog2(NUM_BLOCKS)); LEVELS = clog2(NUM_BLOCKS); LAT = LEVELS + 1.
REQ-005 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-007 valid_in  input  1  candidate beat present.
REQ-008 ready_out  output  1  block accepts a beat this cycle.
REQ-009 curr_time_in  input  18  frame time tag, passed through.
REQ-010 x_in / y_in  input  11 / 10  pixel coordinate, passed through.
REQ-011 t_in  input  NUM_BLOCKS x T_WIDTH  per-block hit distance.
REQ-012 hit_in  input  NUM_BLOCKS  per-block ray-hit flag.
REQ-013 attr_in  input  NUM_BLOCKS x ATTR_WIDTH  per-block attribute word.
REQ-014 t_max_in  input  T_WIDTH  far-clip distance, sampled with the beat.
REQ-015 valid_out  output  1  result beat present.
REQ-016 ready_in  input  1  downstream accepts result.
REQ-017 curr_time_out / x_out / y_out  output  18 / 11 / 10  tags aligned to result.
REQ-018 block_index_out  output  IDX_W  winning block index.
REQ-019 t_out  output  T_WIDTH  winning distance.
REQ-020 attr_out  output  ATTR_WIDTH  winning attribute word.
REQ-021 block_visible_out  output  1  1 = a block won, 0 = miss.

Function
REQ-022 Candidate i qualifies iff hit_in[i]=1 and t_in[i] <= t_max_in (unsigned; equality qualifies).
REQ-023 Stage 0 registers each candidate as {qualify, t, index, attr} at acceptance; non-qualifying candidates carry t = all-ones.
REQ-024 Stages 1..LEVELS each form a registered binary min-reduction level; odd element at a level passes through unchanged.
REQ-025 Compare rule: qualifying beats non-qualifying; among qualifying, smaller t wins; equal t -> lower index wins.
REQ-026 Tags (time, x, y) travel in lockstep registers with the tree, one per stage.
REQ-027 Latency: an accepted beat appears on valid_out exactly LAT cycles later absent stall (NUM_BLOCKS=12 -> 5; NUM_BLOCKS=1 -> 1).
REQ-028 Handshake: beat accepted when valid_in && ready_out; result transferred when valid_out && ready_in.
REQ-029 ready_out = !(valid_out && !ready_in); stall freezes every stage, including valid bits, with no data loss or duplication.
REQ-030 Bubbles (valid=0 stages) propagate and are not collapsed; throughput one beat per cycle when ready_in=1.
REQ-031 Miss (no qualifying candidate): block_visible_out=0, block_index_out=0, t_out=all-ones, attr_out=0; tags still valid.
REQ-032 Outputs hold value while valid_out && !ready_in; outputs when valid_out=0 are don't-care except block_visible_out=0.
REQ-033 Inputs other than valid_in are sampled only on acceptance; changes while ready_out=0 have no effect.

Reset
REQ-034 rst_in low clears all stage valid bits immediately, without a clock edge; valid_out=0, block_visible_out=0, ready_out=1.
REQ-035 Reset mid-stream discards all in-flight beats; none emitted after deassertion.
REQ-036 Data/tag registers need not be reset; first valid_out occurs LAT cycles after first post-reset acceptance.

Verification
REQ-037 NUM_BLOCKS=12, hit=all, t[i]=100-i, t_max=max, ready_in=1 -> 5 cycles later index=11, t=89, visible=1.
REQ-038 hit only at 3 and 7, t[3]=t[7]=50 -> index=3, t=50; repeat with t_max=49 -> visible=0, t=all-ones, index=0.
REQ-039 Stream 20 beats back-to-back, ready_in toggled 1/0 randomly -> 20 results, order and tags preserved, none lost/duplicated, valid_out held during stall.
REQ-040 Assert rst_in low with 3 beats in flight -> valid_out drops same cycle; after release, no stale beats emerge.
REQ-041 NUM_BLOCKS=1 and NUM_BLOCKS=5 builds, randomized t/hit vs. reference min model -> bit-exact match, latencies 1 and 4.
